reservation_scheduler: RTL and testbench

Shares the reservation free-list (reservation_counter) between NUM_REQ malloc requesters and the deallocation unit. It arbitrates allocations round-robin and sequences the counter's enqueue/dequeue strobes. It rejects frees of blocks that are not currently allocated, and bounds how long frees can starve allocations. It sits between the malloc/dealloc units and a single reservation_counter instance in the MPU.

---
 rtl/reservation_scheduler_pkg.sv | 18 +
 rtl/reservation_scheduler_rr_arbiter.sv | 32 +++
 rtl/reservation_scheduler.sv | 168 ++++++++++++++++
 tb/tb_reservation_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_scheduler_pkg.sv
// Shared definitions for the reservation scheduler slice of the MPU.
// Contents:
//   BLOCK_COUNT / BLOCK_COUNT_BITS : number of reservation blocks and ID width
//   block_id_t                     : block identifier type
//   rsched_state_t                 : scheduler FSM state encoding
package reservation_scheduler_pkg;

  localparam int BLOCK_COUNT      = 8;
  localparam int BLOCK_COUNT_BITS = $clog2(BLOCK_COUNT);

  typedef logic [BLOCK_COUNT_BITS-1:0] block_id_t;

  typedef enum logic {
    RS_IDLE  = 1'b0,
    RS_GRANT = 1'b1
  } rsched_state_t;

endpackage

// File: rtl/reservation_scheduler_rr_arbiter.sv
// Pointer-based round-robin arbiter.
// Scans the request vector starting at index ptr, wrapping at NUM_REQ.
// The first set request found wins.
// Ports:
//   req : per-requester request level
//   ptr : index with the highest priority this cycle
//   gnt : one-hot winner, all zero when req is zero
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_scheduler.sv
// Shares one reservation free-list (reservation_counter) between NUM_REQ
// malloc requesters and the deallocation unit.
//
// Allocation is round-robin and takes two cycles. In the IDLE cycle the
// counter is dequeued. In the GRANT cycle the counter's registered
// rc_new_id is returned together with a one-hot grant pulse.
//
// Frees have priority over allocations. The exception is after
// FREE_BURST_MAX consecutive frees while some allocation is pending and a
// block is available; in that case one allocation is forced.
//
// An allocated-block bitmap rejects frees of blocks that are not out. Such
// a free is still consumed, and free_err pulses in the following cycle.
//
// Handshake: a free transfers in every cycle where free_valid && free_ready.
// free_ready never depends on free_valid. alloc_req is a level that must be
// held from the winning IDLE cycle through its grant cycle.
//
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   alloc_req / alloc_gnt  : requester levels / one-hot one-cycle grant
//   alloc_id               : granted block ID, zero when no grant
//   free_valid/free_id     : free request from the dealloc unit
//   free_ready             : free accepted this cycle
//   free_err               : pulse, cycle after freeing an unallocated ID
//   no_blocks              : counter empty while a request is pending
//   rc_enqueue/rc_dequeue  : counter strobes
//   rc_freed_id            : ID pushed back to the counter
//   rc_new_id              : counter head, valid the cycle after dequeue
//   rc_full/rc_empty/rc_rdy: counter status
//   state                  : FSM state, for debug
module reservation_scheduler
  import reservation_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int FREE_BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] alloc_req,
  output logic [NUM_REQ-1:0] alloc_gnt,
  output block_id_t          alloc_id,
  input  logic               free_valid,
  input  block_id_t          free_id,
  output logic               free_ready,
  output logic               free_err,
  output logic               no_blocks,
  output logic               rc_enqueue,
  output logic               rc_dequeue,
  output block_id_t          rc_freed_id,
  input  block_id_t          rc_new_id,
  input  logic               rc_full,
  input  logic               rc_empty,
  input  logic               rc_rdy,
  output rsched_state_t      state
);

  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(FREE_BURST_MAX + 1);

  rsched_state_t          state_q;
  logic [PTR_W-1:0]       winner_q;
  logic [PTR_W-1:0]       rr_ptr_q;
  logic [BURST_W-1:0]     burst_q;
  logic [BLOCK_COUNT-1:0] bitmap_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               any_req;
  logic               force_alloc;
  logic               free_fire;
  logic               free_hit;
  logic               alloc_fire;
  logic [PTR_W-1:0]   rr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req (alloc_req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  // One-hot winner to index.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = PTR_W'(i);
    end
  end

  assign any_req = |alloc_req;

  // Frees have starved allocation long enough. Only force when an
  // allocation can actually proceed; otherwise keep draining frees.
  assign force_alloc = (burst_q == BURST_W'(FREE_BURST_MAX)) && any_req && !rc_empty;

  assign free_ready = (state_q == RS_IDLE) && rc_rdy && !rc_full && !force_alloc;
  assign free_fire  = free_valid && free_ready;
  assign free_hit   = bitmap_q[free_id];
  assign alloc_fire = (state_q == RS_IDLE) && !free_fire && any_req && !rc_empty && rc_rdy;

  // Unallocated IDs are consumed but never reach the counter, so duplicates
  // cannot enter the free-list.
  assign rc_enqueue  = free_fire && free_hit;
  assign rc_dequeue  = alloc_fire;
  assign rc_freed_id = free_id;

  assign no_blocks = rc_empty && any_req;
  assign state     = state_q;

  // rc_new_id is only meaningful in the GRANT cycle.
  assign alloc_id = (state_q == RS_GRANT) ? rc_new_id : '0;

  assign rr_next = (winner_q == PTR_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RS_IDLE;
      winner_q  <= '0;
      rr_ptr_q  <= '0;
      burst_q   <= '0;
      bitmap_q  <= '0;
      alloc_gnt <= '0;
      free_err  <= 1'b0;
    end else begin
      alloc_gnt <= '0;
      free_err  <= free_fire && !free_hit;
      case (state_q)
        RS_IDLE: begin
          if (free_fire) begin
            if (free_hit) bitmap_q[free_id] <= 1'b0;
            if (any_req) begin
              if (burst_q != BURST_W'(FREE_BURST_MAX)) burst_q <= burst_q + 1'b1;
            end else begin
              burst_q <= '0;
            end
          end else if (alloc_fire) begin
            // The grant pulse is registered here so it lines up with the
            // counter's registered rc_new_id in the GRANT cycle.
            winner_q  <= arb_idx;
            alloc_gnt <= arb_gnt;
            burst_q   <= '0;
            state_q   <= RS_GRANT;
          end else if (!any_req) begin
            burst_q <= '0;
          end
        end
        RS_GRANT: begin
          bitmap_q[rc_new_id] <= 1'b1;
          rr_ptr_q            <= rr_next;
          if (!any_req) burst_q <= '0;
          state_q <= RS_IDLE;
        end
        default: state_q <= RS_IDLE;
      endcase
    end
  end

  // A requester that won in IDLE must still be requesting in its grant cycle.
  grant_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == RS_GRANT) |-> alloc_req[winner_q]);

  strobes_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(rc_enqueue && rc_dequeue));

endmodule

// File: tb/tb_reservation_scheduler.sv
module tb_reservation_scheduler;
  import reservation_scheduler_pkg::*;

  localparam int NR = 4;
  localparam int W  = NR + BLOCK_COUNT_BITS;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] alloc_req;
  logic [NR-1:0] alloc_gnt;
  block_id_t     alloc_id;
  logic          free_valid;
  block_id_t     free_id;
  logic          free_ready;
  logic          free_err;
  logic          no_blocks;
  logic          rc_enqueue;
  logic          rc_dequeue;
  block_id_t     rc_freed_id;
  block_id_t     rc_new_id;
  logic          rc_full;
  logic          rc_empty;
  logic          rdy_drv;
  rsched_state_t state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  reservation_scheduler #(.NUM_REQ(NR), .FREE_BURST_MAX(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_req   (alloc_req),
    .alloc_gnt   (alloc_gnt),
    .alloc_id    (alloc_id),
    .free_valid  (free_valid),
    .free_id     (free_id),
    .free_ready  (free_ready),
    .free_err    (free_err),
    .no_blocks   (no_blocks),
    .rc_enqueue  (rc_enqueue),
    .rc_dequeue  (rc_dequeue),
    .rc_freed_id (rc_freed_id),
    .rc_new_id   (rc_new_id),
    .rc_full     (rc_full),
    .rc_empty    (rc_empty),
    .rc_rdy      (rdy_drv),
    .state       (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reservation counter model (FIFO of free IDs) ----------------
  logic [BLOCK_COUNT_BITS-1:0] fl_mem [16];
  logic [4:0] fl_rd, fl_wr, fl_cnt;
  assign fl_cnt   = fl_wr - fl_rd;
  assign rc_empty = (fl_cnt == 5'd0);
  assign rc_full  = (fl_cnt == 5'(BLOCK_COUNT));

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BLOCK_COUNT; i++) fl_mem[i] <= BLOCK_COUNT_BITS'(i);
      fl_rd     <= '0;
      fl_wr     <= 5'(BLOCK_COUNT);
      rc_new_id <= '0;
    end else begin
      if (rc_dequeue) begin
        rc_new_id <= fl_mem[fl_rd[3:0]];
        fl_rd     <= fl_rd + 5'd1;
      end
      if (rc_enqueue) begin
        fl_mem[fl_wr[3:0]] <= rc_freed_id;
        fl_wr              <= fl_wr + 5'd1;
      end
    end
  end

  // ---------------- scoreboard: grant monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (alloc_gnt != '0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL grant_unexpected: got gnt=%b id=%0d, want no grant", alloc_gnt, alloc_id);
      end else begin
        e = exp_q.pop_front();
        if ({alloc_gnt, alloc_id} !== e) begin
          bad++;
          $display("FAIL grant: got gnt=%b id=%0d, want gnt=%b id=%0d",
                   alloc_gnt, alloc_id, e[W-1:BLOCK_COUNT_BITS], e[BLOCK_COUNT_BITS-1:0]);
        end
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    alloc_req  = '0;
    free_valid = 1'b0;
    free_id    = '0;
    rdy_drv    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Waits until every queued grant has been observed; returns edges waited.
  task automatic wait_grants(input int max_cyc, output int cyc);
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (exp_q.size() == 0) break;
      if (cyc >= max_cyc) begin
        total++;
        bad++;
        $display("FAIL grant_timeout: got %0d grants outstanding, want 0", exp_q.size());
        exp_q.delete();
        break;
      end
    end
    #1;
  endtask

  task automatic alloc_one(input logic [NR-1:0] mask, input logic [NR-1:0] g, input int id);
    int cyc;
    exp_q.push_back({g, BLOCK_COUNT_BITS'(id)});
    alloc_req = mask;
    wait_grants(8, cyc);
    check("alloc_latency", cyc, 2);
    alloc_req = '0;
  endtask

  typedef struct {
    logic [NR-1:0] req;
    logic          fv;
    logic [2:0]    fid;
    logic          rdy;
    logic          fr, enq, deq, nob;
    logic          push;
    logic [NR-1:0] pgnt;
    logic [2:0]    pid;
  } vec_t;

  vec_t tbl [12];

  // ---------------- test sequence ----------------
  initial begin
    int cyc;

    // Fairness / rc_rdy vectors, starting from an empty counter.
    tbl[0]  = '{4'b0001, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0};
    tbl[1]  = '{4'b0001, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0};
    tbl[2]  = '{4'b0001, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 3'd0};
    tbl[3]  = '{4'b0001, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0};
    tbl[4]  = '{4'b0001, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0};
    tbl[5]  = '{4'b0001, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0};
    tbl[6]  = '{4'b0001, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 3'd1};
    tbl[7]  = '{4'b0001, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0};
    tbl[8]  = '{4'b0001, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0};
    tbl[9]  = '{4'b0001, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 3'd2};
    tbl[10] = '{4'b0001, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0};
    tbl[11] = '{4'b0000, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0};

    // 1. reset state and single requester
    do_reset();
    check("rst_gnt", alloc_gnt, 0);
    check("rst_id", alloc_id, 0);
    check("rst_err", free_err, 0);
    check("rst_state", 32'(state), 32'(RS_IDLE));
    check("rst_nob", no_blocks, 0);
    alloc_one(4'b0001, 4'b0001, 0);
    alloc_one(4'b0001, 4'b0001, 1);

    // 2. all four requesters held: round-robin on alternating cycles
    do_reset();
    exp_q.push_back({4'b0001, 3'd0});
    exp_q.push_back({4'b0010, 3'd1});
    exp_q.push_back({4'b0100, 3'd2});
    exp_q.push_back({4'b1000, 3'd3});
    exp_q.push_back({4'b0001, 3'd4});
    alloc_req = 4'b1111;
    wait_grants(20, cyc);
    check("rr_cycles", cyc, 10);
    alloc_req = '0;

    // 3. free of an unallocated ID (one block out so the counter is not full)
    do_reset();
    alloc_one(4'b0001, 4'b0001, 0);
    free_valid = 1'b1;
    free_id    = 3'd5;
    #1;
    check("bad_free_ready", free_ready, 1);
    check("bad_free_enq", rc_enqueue, 0);
    tick();
    free_valid = 1'b0;
    check("bad_free_err", free_err, 1);
    check("bad_free_len", fl_cnt, 7);
    tick();
    check("bad_free_err_clr", free_err, 0);

    // 4. exhaustion and refill
    do_reset();
    for (int i = 0; i < BLOCK_COUNT; i++) alloc_one(4'b0001, 4'b0001, i);
    alloc_req = 4'b0010;
    #1;
    check("exh_nob", no_blocks, 1);
    repeat (3) tick();
    check("exh_nob_held", no_blocks, 1);
    check("exh_idle", 32'(state), 32'(RS_IDLE));
    exp_q.push_back({4'b0010, 3'd3});
    free_valid = 1'b1;
    free_id    = 3'd3;
    #1;
    check("refill_ready", free_ready, 1);
    check("refill_enq", rc_enqueue, 1);
    check("refill_id", rc_freed_id, 3);
    tick();
    free_valid = 1'b0;
    #1;
    check("refill_nob", no_blocks, 0);
    check("refill_deq", rc_dequeue, 1);
    wait_grants(6, cyc);
    check("refill_latency", cyc, 2);
    alloc_req = '0;

    // 5. free-burst fairness and rc_rdy stall (table)
    for (int i = 0; i < 12; i++) begin
      alloc_req  = tbl[i].req;
      free_valid = tbl[i].fv;
      free_id    = tbl[i].fid;
      rdy_drv    = tbl[i].rdy;
      if (tbl[i].push) exp_q.push_back({tbl[i].pgnt, tbl[i].pid});
      #1;
      check($sformatf("vec%0d_ready", i), free_ready, tbl[i].fr);
      check($sformatf("vec%0d_enq", i), rc_enqueue, tbl[i].enq);
      check($sformatf("vec%0d_deq", i), rc_dequeue, tbl[i].deq);
      check($sformatf("vec%0d_nob", i), no_blocks, tbl[i].nob);
      tick();
    end
    free_valid = 1'b0;
    rdy_drv    = 1'b1;
    check("fair_drain", exp_q.size(), 0);

    // 6. reset during the GRANT cycle
    do_reset();
    alloc_one(4'b0001, 4'b0001, 0);
    exp_q.push_back({4'b0100, 3'd1});
    alloc_req = 4'b0100;
    tick();
    check("mid_state", 32'(state), 32'(RS_GRANT));
    rst_n = 1'b0;
    tick();
    check("mid_gnt", alloc_gnt, 0);
    check("mid_id", alloc_id, 0);
    check("mid_idle", 32'(state), 32'(RS_IDLE));
    alloc_req = '0;
    rst_n     = 1'b1;
    alloc_one(4'b0011, 4'b0001, 0);
    free_valid = 1'b1;
    free_id    = 3'd1;
    #1;
    check("mid_free1_enq", rc_enqueue, 0);
    tick();
    free_id = 3'd0;
    #1;
    check("mid_free1_err", free_err, 1);
    check("mid_free0_enq", rc_enqueue, 1);
    tick();
    free_valid = 1'b0;
    check("mid_free0_err", free_err, 0);
    check("mid_len", fl_cnt, 8);

    tick();
    check("final_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
